// File: rtl/tone_meter_pkg.sv
// Shared types and default constants for the tone period meter.
package tone_meter_pkg;

  localparam int CNT_W      = 24;
  localparam int TIMEOUT    = 1000000;
  localparam int MIN_PERIOD = 4;
  localparam int TOL        = 1;
  localparam int LOCK_N     = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TRACK
  } state_t;

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits one-cycle rise/fall pulses.
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s0;
  logic s1;
  logic d;

  // NOTE: non-blocking assignments make s0 -> s1 -> d a true shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s0 <= din;
      s1 <= s0;
      d  <= s1;
    end
  end

  assign rise = s1 & ~d;
  assign fall = ~s1 & d;

endmodule

// File: rtl/tone_period_meter.sv
// Measures period and high time of a square-wave tone; reports lock, loss and glitches.
module tone_period_meter #(
  parameter int CNT_W      = tone_meter_pkg::CNT_W,
  parameter int TIMEOUT    = tone_meter_pkg::TIMEOUT,
  parameter int MIN_PERIOD = tone_meter_pkg::MIN_PERIOD,
  parameter int TOL        = tone_meter_pkg::TOL,
  parameter int LOCK_N     = tone_meter_pkg::LOCK_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             tone_present,
  output logic             timeout,
  output logic             glitch
);

  import tone_meter_pkg::*;

  localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [CNT_W:0]   MIN_P   = (CNT_W + 1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_N);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic             rise;
  logic             fall;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   diff;
  logic [MW-1:0]    match_next;
  logic             accept;
  logic             at_limit;

  tone_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (tone_in),
    .rise (rise),
    .fall (fall)
  );

  // The period register doubles as the previous accepted period for matching.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
    if (cnt_inc >= {1'b0, period}) diff = cnt_inc - {1'b0, period};
    else                           diff = {1'b0, period} - cnt_inc;
    if (diff > TOL_V)              match_next = '0;
    else if (match_cnt >= LOCK_M)  match_next = LOCK_M;
    else                           match_next = match_cnt + MW'(1);
    accept   = rise && (cnt_inc >= MIN_P);
    at_limit = (cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      tone_present <= 1'b0;
      timeout      <= 1'b0;
      glitch       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      glitch       <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) state <= ARMED;
        end
        default: begin
          if (fall) high_time <= cnt_inc[CNT_W-1:0];
          if (accept) begin
            period       <= cnt_inc[CNT_W-1:0];
            period_valid <= 1'b1;
            match_cnt    <= match_next;
            tone_present <= (match_next >= LOCK_M);
            state        <= TRACK;
            cnt          <= '0;
          end else if (at_limit) begin
            // Timeout outranks a too-early rise arriving in the same cycle.
            state        <= IDLE;
            timeout      <= 1'b1;
            tone_present <= 1'b0;
            match_cnt    <= '0;
            cnt          <= '0;
          end else begin
            if (rise) glitch <= 1'b1;
            if (cnt != TO_SAT) cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed and random tone stimulus on two meters (TOL=1, TOL=0) against a timestamp model.
module tb_tone_period_meter;

  localparam int CW    = 16;
  localparam int TMO   = 100;
  localparam int MINP  = 4;
  localparam int LOCKN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tone_in = 1'b0;

  logic [CW-1:0] a_period, a_high, b_period, b_high;
  logic a_pv, a_tp, a_to, a_gl;
  logic b_pv, b_tp, b_to, b_gl;

  tone_period_meter #(.CNT_W(CW), .TIMEOUT(TMO), .MIN_PERIOD(MINP), .TOL(1), .LOCK_N(LOCKN)) u_tol1 (
    .clk(clk), .rst(rst), .tone_in(tone_in), .period(a_period), .high_time(a_high),
    .period_valid(a_pv), .tone_present(a_tp), .timeout(a_to), .glitch(a_gl)
  );

  tone_period_meter #(.CNT_W(CW), .TIMEOUT(TMO), .MIN_PERIOD(MINP), .TOL(0), .LOCK_N(LOCKN)) u_tol0 (
    .clk(clk), .rst(rst), .tone_in(tone_in), .period(b_period), .high_time(b_high),
    .period_valid(b_pv), .tone_present(b_tp), .timeout(b_to), .glitch(b_gl)
  );

  always #5 clk = ~clk;

  // Model tracks sample timestamps of the tone rather than a cycle counter.
  typedef struct {
    int t;
    int last;
    int period;
    int high;
    int match;
    bit active;
    bit prev;
    bit present;
    bit pv;
    bit to;
    bit gl;
  } mdl_t;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic pv;
    logic tp;
    logic to;
    logic gl;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int n_to  = 0;
  int n_gl  = 0;
  int n_tpb = 0;

  mdl_t m_a, m_b;
  exp_t q_a[$];
  exp_t q_b[$];

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.t = 0; m.last = 0; m.period = 0; m.high = 0; m.match = 0;
    m.active = 0; m.prev = 0; m.present = 0; m.pv = 0; m.to = 0; m.gl = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m_in, input bit v, input int tol);
    mdl_t m;
    bit rise;
    bit fall;
    int el;
    int dif;
    m = m_in;
    rise = v & ~m.prev;
    fall = ~v & m.prev;
    m.t = m.t + 1;
    m.pv = 0; m.to = 0; m.gl = 0;
    if (!m.active) begin
      if (rise) begin
        m.active = 1;
        m.last   = m.t;
      end
    end else begin
      el = m.t - m.last;
      if (fall) m.high = el;
      if (rise && el >= MINP) begin
        dif = (el > m.period) ? el - m.period : m.period - el;
        if (dif <= tol) m.match = (m.match + 1 > LOCKN) ? LOCKN : m.match + 1;
        else            m.match = 0;
        m.present = (m.match >= LOCKN);
        m.period  = el;
        m.pv      = 1;
        m.last    = m.t;
      end else if (el == TMO) begin
        m.active  = 0;
        m.present = 0;
        m.match   = 0;
        m.to      = 1;
      end else if (rise) begin
        m.gl = 1;
      end
    end
    m.prev = v;
    return m;
  endfunction

  function automatic exp_t to_exp(input mdl_t m);
    exp_t e;
    e.period = CW'(m.period);
    e.high   = CW'(m.high);
    e.pv     = m.pv;
    e.tp     = m.present;
    e.to     = m.to;
    e.gl     = m.gl;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic [CW-1:0] p, input logic [CW-1:0] h,
                     input logic pv, input logic tp, input logic to, input logic gl);
    check({who, ".period"},       32'(p),  32'(e.period));
    check({who, ".high_time"},    32'(h),  32'(e.high));
    check({who, ".period_valid"}, 32'(pv), 32'(e.pv));
    check({who, ".tone_present"}, 32'(tp), 32'(e.tp));
    check({who, ".timeout"},      32'(to), 32'(e.to));
    check({who, ".glitch"},       32'(gl), 32'(e.gl));
  endtask

  // Outputs lag the sampled tone by two clocks, hence the two-entry prefill.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_a = mdl_reset();
    m_b = mdl_reset();
    q_a.delete();
    q_b.delete();
    repeat (2) begin
      q_a.push_back(to_exp(m_a));
      q_b.push_back(to_exp(m_b));
    end
    cmp("rst_tol1", to_exp(m_a), a_period, a_high, a_pv, a_tp, a_to, a_gl);
    cmp("rst_tol0", to_exp(m_b), b_period, b_high, b_pv, b_tp, b_to, b_gl);
  endtask

  task automatic step(input logic v);
    exp_t e;
    tone_in = v;
    @(posedge clk);
    #1;
    m_a = mdl_next(m_a, v, 1);
    m_b = mdl_next(m_b, v, 0);
    q_a.push_back(to_exp(m_a));
    q_b.push_back(to_exp(m_b));
    e = q_a.pop_front();
    cmp("tol1", e, a_period, a_high, a_pv, a_tp, a_to, a_gl);
    e = q_b.pop_front();
    cmp("tol0", e, b_period, b_high, b_pv, b_tp, b_to, b_gl);
    if (a_to) n_to++;
    if (a_gl) n_gl++;
    if (b_tp) n_tpb++;
  endtask

  task automatic tone(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  initial begin
    do_reset();

    // Steady divide-by-16 tone: lock after two matching periods.
    repeat (8) tone(8, 8);
    check("lock16.period", 32'(a_period), 32'd16);
    check("lock16.high", 32'(a_high), 32'd8);
    check("lock16.present", 32'(a_tp), 32'd1);

    // Tone lost: single timeout pulse, period retained.
    n_to = 0;
    repeat (120) step(1'b0);
    check("loss.timeouts", 32'(n_to), 32'd1);
    check("loss.present", 32'(a_tp), 32'd0);
    check("loss.period", 32'(a_period), 32'd16);

    // Period change 16 -> 20, then relock.
    repeat (6) tone(8, 8);
    repeat (5) tone(10, 10);
    check("relock20.period", 32'(a_period), 32'd20);
    check("relock20.present", 32'(a_tp), 32'd1);

    // Runt pulse two cycles after a rise.
    repeat (4) tone(8, 8);
    n_gl = 0;
    step(1'b1); step(1'b0); step(1'b1);
    repeat (13) step(1'b0);
    repeat (2) tone(8, 8);
    check("glitch.count", 32'(n_gl), 32'd1);
    check("glitch.period", 32'(a_period), 32'd16);

    // Reset mid-period while locked.
    repeat (4) tone(8, 8);
    repeat (4) step(1'b1);
    do_reset();
    repeat (4) tone(8, 8);
    check("post_rst.period", 32'(a_period), 32'd16);

    // Jitter 16/17: TOL=1 stays locked, TOL=0 never locks.
    repeat (110) step(1'b0);
    n_tpb = 0;
    repeat (10) begin
      tone(8, 8);
      tone(8, 9);
    end
    check("jitter.tol0_locks", 32'(n_tpb), 32'd0);
    check("jitter.tol1_present", 32'(a_tp), 32'd1);

    // Random tones with occasional dropouts and resets.
    repeat (300) begin
      tone(int'($urandom_range(1, 20)), int'($urandom_range(1, 25)));
      if ($urandom_range(0, 19) == 0) repeat (110) step(1'b0);
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    repeat (4) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
